// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one variable-latency memory bus between instruction
// fetch (m0) and data access (m1), with streak fairness, flush drop and watchdog.
module mem_bus_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int TIMEOUT         = 255,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  m0_req_i,
   input  logic [ADDR_W-1:0]     m0_addr_i,
   output logic [DATA_W-1:0]     m0_rdata_o,
   output logic                  m0_ack_o,
   input  logic                  m1_req_i,
   input  logic                  m1_we_i,
   input  logic [ADDR_W-1:0]     m1_addr_i,
   input  logic [DATA_W-1:0]     m1_wdata_i,
   input  logic [DATA_W/8-1:0]   m1_sel_i,
   output logic [DATA_W-1:0]     m1_rdata_o,
   output logic                  m1_ack_o,
   output logic                  bus_err_o,
   output logic                  s_cyc_o,
   output logic                  s_we_o,
   output logic [ADDR_W-1:0]     s_addr_o,
   output logic [DATA_W-1:0]     s_wdata_o,
   output logic [DATA_W/8-1:0]   s_sel_o,
   input  logic [DATA_W-1:0]     s_rdata_i,
   input  logic                  s_ack_i,
   output logic                  stallreq_if_o,
   output logic                  stallreq_mem_o
);

   localparam int SEL_W = DATA_W / 8;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam int STR_W = $clog2(MAX_DATA_STREAK + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t            state;
   logic [TMR_W-1:0]  timer;
   logic [STR_W-1:0]  streak;
   logic              drop;
   logic              grant_m0;
   logic              grant_m1;
   logic              timeout_hit;
   logic              done;

   function automatic logic [STR_W-1:0] streak_inc(input logic [STR_W-1:0] v);
      return (v == STR_W'(MAX_DATA_STREAK)) ? v : v + 1'b1;
   endfunction

   assign stallreq_if_o  = m0_req_i & ~m0_ack_o;
   assign stallreq_mem_o = m1_req_i & ~m1_ack_o;

   assign timeout_hit = (timer == TMR_W'(TIMEOUT - 1));
   assign done        = s_ack_i | timeout_hit;

   // A master seeing its ack this cycle still holds its old request high, so it is
   // masked; when m1 is the one masked, the slot stays empty rather than going to m0.
   always_comb begin
      grant_m0 = 1'b0;
      grant_m1 = 1'b0;
      if (state == IDLE) begin
         if (stallreq_if_o && m1_req_i && (streak == STR_W'(MAX_DATA_STREAK)))
            grant_m0 = 1'b1;
         else if (m1_req_i)
            grant_m1 = ~m1_ack_o;
         else
            grant_m0 = stallreq_if_o;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         timer      <= '0;
         streak     <= '0;
         drop       <= 1'b0;
         s_cyc_o    <= 1'b0;
         s_we_o     <= 1'b0;
         s_addr_o   <= '0;
         s_wdata_o  <= '0;
         s_sel_o    <= '0;
         m0_ack_o   <= 1'b0;
         m1_ack_o   <= 1'b0;
         m0_rdata_o <= '0;
         m1_rdata_o <= '0;
         bus_err_o  <= 1'b0;
      end else begin
         m0_ack_o  <= 1'b0;
         m1_ack_o  <= 1'b0;
         bus_err_o <= 1'b0;
         case (state)
            IDLE: begin
               timer <= '0;
               drop  <= 1'b0;
               if (!m1_req_i)
                  streak <= '0;
               if (grant_m1) begin
                  s_cyc_o   <= 1'b1;
                  s_we_o    <= m1_we_i;
                  s_addr_o  <= m1_addr_i;
                  s_wdata_o <= m1_wdata_i;
                  s_sel_o   <= m1_sel_i;
                  streak    <= streak_inc(streak);
                  state     <= BUSY_D;
               end else if (grant_m0) begin
                  s_cyc_o   <= 1'b1;
                  s_we_o    <= 1'b0;
                  s_addr_o  <= m0_addr_i;
                  s_wdata_o <= '0;
                  s_sel_o   <= {SEL_W{1'b1}};
                  streak    <= '0;
                  state     <= BUSY_I;
               end
            end
            BUSY_I: begin
               timer <= timer + 1'b1;
               if (flush_i)
                  drop <= 1'b1;
               if (done) begin
                  s_cyc_o <= 1'b0;
                  state   <= IDLE;
                  // A flushed fetch still finishes on the bus but is never delivered.
                  if (!(drop || flush_i)) begin
                     m0_ack_o   <= 1'b1;
                     m0_rdata_o <= s_ack_i ? s_rdata_i : '0;
                     bus_err_o  <= ~s_ack_i;
                  end
               end
            end
            BUSY_D: begin
               timer <= timer + 1'b1;
               if (done) begin
                  s_cyc_o    <= 1'b0;
                  state      <= IDLE;
                  m1_ack_o   <= 1'b1;
                  m1_rdata_o <= s_ack_i ? s_rdata_i : '0;
                  bus_err_o  <= ~s_ack_i;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
